// File: rtl/clk_div_ctrl.sv
// Programmable clock divider (R = cur_div+1, 2..16) with a req/ack ratio-change handshake.
// Define CLK_DIV_CTRL_ODD_EN to also accept odd ratios (high phase one cycle longer).
module clk_div_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       req,
  input  logic [3:0] div_in,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [3:0] cur_div,
  output logic       clk_out,
  output logic       tick
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] cur_div_n;
  logic [3:0] pend_div, pend_div_n;
  logic       pend, pend_n;
  logic       armed, armed_n;
  logic       ack_n, err_n, clk_out_n, tick_n;
  logic       boundary, sample, div_ok;
  logic [4:0] hi_n;

  // last cycle of the current period
  assign boundary = (state != IDLE) && (cnt == cur_div);
  // a held req is ignored until it has dropped once (armed)
  assign sample   = req && armed && !pend;

`ifdef CLK_DIV_CTRL_ODD_EN
  assign div_ok = (div_in != 4'd0);
`else
  assign div_ok = div_in[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = RUN;
      RUN:     if (!en) state_n = boundary ? IDLE : DRAIN;
      DRAIN:   if (en) state_n = RUN;
               else if (boundary) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n      = 4'd0;
    cur_div_n  = cur_div;
    pend_n     = pend;
    pend_div_n = pend_div;
    ack_n      = 1'b0;
    err_n      = 1'b0;
    armed_n    = armed;
    if (!req) armed_n = 1'b1;
    if (state != IDLE && !boundary) cnt_n = cnt + 4'd1;
    // a pending ratio lands on the cycle after a boundary (or at once if stopped)
    if (pend && (boundary || state == IDLE)) begin
      cur_div_n = pend_div;
      pend_n    = 1'b0;
      ack_n     = 1'b1;
    end
    if (sample) begin
      armed_n = 1'b0;
      if (!div_ok) begin
        err_n = 1'b1;
      end else if (state == IDLE) begin
        cur_div_n = div_in;
        ack_n     = 1'b1;
      end else begin
        pend_n     = 1'b1;
        pend_div_n = div_in;
      end
    end
    hi_n      = ({1'b0, cur_div_n} + 5'd2) >> 1;
    clk_out_n = (state_n != IDLE) && ({1'b0, cnt_n} < hi_n);
    tick_n    = (state_n == RUN) && (cnt_n == 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      cur_div  <= 4'd1;
      pend     <= 1'b0;
      pend_div <= 4'd0;
      armed    <= 1'b1;
      ack      <= 1'b0;
      err      <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      cur_div  <= cur_div_n;
      pend     <= pend_n;
      pend_div <= pend_div_n;
      armed    <= armed_n;
      ack      <= ack_n;
      err      <= err_n;
      clk_out  <= clk_out_n;
      tick     <= tick_n;
    end
  end

  assign busy = pend;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: ack/err go through a scoreboard queue,
// waveform patterns are checked cycle by cycle against hand-computed values.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, req;
  logic [3:0] div_in;
  logic       ack, err, busy, clk_out, tick;
  logic [3:0] cur_div;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [3:0] div;
  } exp_t;
  exp_t sb_q[$];

  clk_div_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .div_in(div_in),
    .ack(ack), .err(err), .busy(busy), .cur_div(cur_div),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [3:0] d);
    exp_t e;
    e.is_err = is_err;
    e.div    = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_pulse(input string name, input bit want_err);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 24; n++) begin
      step();
      if (want_err ? err : ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1);
  endtask

  // scoreboard monitor: every ack/err pulse must match the next expected response
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ack || err)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected ack=%0b err=%0b cur_div=%0d t=%0t", ack, err, cur_div, $time);
      end else begin
        e = sb_q.pop_front();
        if (err != e.is_err || ack != !e.is_err || cur_div != e.div) begin
          errors++;
          $display("FAIL sb_resp got ack=%0b err=%0b cur_div=%0d want err=%0b cur_div=%0d t=%0t",
                   ack, err, cur_div, e.is_err, e.div, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; req = 1'b0; div_in = 4'd0;
    step();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_cur_div", cur_div, 1);
    reset = 1'b0;
    step();
    chk("idle_clk_out", clk_out, 0);

    // R=2 free-running
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r2_clk_out", clk_out, (i % 2 == 0));
      chk("r2_tick", tick, (i % 2 == 0));
      chk("r2_cur_div", cur_div, 1);
    end

    // change to D=7 at cnt=0; boundary is the next cycle
    req = 1'b1; div_in = 4'd7;
    push(1'b0, 4'd7);
    step();
    chk("chg_busy", busy, 1);
    chk("chg_no_early_ack", ack, 0);
    wait_pulse("chg_ack", 1'b0);
    chk("chg_busy_after", busy, 0);
    chk("chg_cur_div", cur_div, 7);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (i == 3) req = 1'b0;
      chk("r8_clk_out", clk_out, ((i % 8) < 4));
      chk("r8_tick", tick, (i % 8 == 0));
      chk("r8_held_req_busy", busy, 0);
    end

    // invalid D=0
    req = 1'b1; div_in = 4'd0;
    push(1'b1, 4'd7);
    wait_pulse("d0_err", 1'b1);
    req = 1'b0;
    step();
    chk("d0_cur_div", cur_div, 7);
    chk("d0_busy", busy, 0);

`ifdef CLK_DIV_CTRL_ODD_EN
    req = 1'b1; div_in = 4'd2;
    push(1'b0, 4'd2);
    wait_pulse("r3_ack", 1'b0);
    req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      chk("r3_clk_out", clk_out, ((i % 3) < 2));
      chk("r3_tick", tick, (i % 3 == 0));
    end
    req = 1'b1; div_in = 4'd7;
    push(1'b0, 4'd7);
    wait_pulse("back_r8_ack", 1'b0);
    req = 1'b0;
`else
    req = 1'b1; div_in = 4'd4;
    push(1'b1, 4'd7);
    wait_pulse("d4_err", 1'b1);
    req = 1'b0;
    step();
    chk("d4_cur_div", cur_div, 7);
`endif

    // R=8, drop en at cnt=3
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        step();
        if (tick) begin seen = 1'b1; break; end
      end
      chk("sync_tick", seen, 1);
    end
    step(); step(); step();
    chk("cnt3_clk_out", clk_out, 1);
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("drain_clk_out", clk_out, 0);
      chk("drain_tick", tick, 0);
    end

    // request while stopped applies at once
    req = 1'b1; div_in = 4'd3;
    push(1'b0, 4'd3);
    step();
    chk("idle_req_ack", ack, 1);
    chk("idle_req_busy", busy, 0);
    chk("idle_req_cur_div", cur_div, 3);
    req = 1'b0;

    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("r4_clk_out", clk_out, ((i % 4) < 2));
      chk("r4_tick", tick, (i % 4 == 0));
    end

    // en dropped then restored before the boundary: period not truncated
    step();
    chk("dr_tick0", tick, 1);
    en = 1'b0;
    step();
    chk("dr_cnt1_clk", clk_out, 1);
    chk("dr_cnt1_tick", tick, 0);
    en = 1'b1;
    step();
    chk("dr_cnt2_clk", clk_out, 0);
    step();
    chk("dr_cnt3_clk", clk_out, 0);
    chk("dr_cnt3_tick", tick, 0);
    step();
    chk("dr_wrap_tick", tick, 1);
    chk("dr_wrap_clk", clk_out, 1);

    // pending change and en=0 meet at the same boundary
    req = 1'b1; div_in = 4'd5;
    push(1'b0, 4'd5);
    step();
    chk("pe_busy", busy, 1);
    en = 1'b0;
    step();
    chk("pe_cnt2_ack", ack, 0);
    step();
    step();
    chk("pe_ack", ack, 1);
    chk("pe_cur_div", cur_div, 5);
    chk("pe_clk_out", clk_out, 0);
    chk("pe_tick", tick, 0);
    chk("pe_busy_clear", busy, 0);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pe_idle_tick", tick, 0);
    end

    // reset while a change is pending
    en = 1'b1;
    step();
    chk("rr_tick", tick, 1);
    req = 1'b1; div_in = 4'd9;
    step();
    chk("rr_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rr_busy0", busy, 0);
    chk("rr_clk_out0", clk_out, 0);
    chk("rr_tick0", tick, 0);
    chk("rr_ack_err0", {ack, err}, 0);
    chk("rr_cur_div", cur_div, 1);
    req = 1'b0; en = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rr_post_busy", busy, 0);
    end
    en = 1'b1;
    step();
    chk("rr_restart_tick", tick, 1);
    chk("rr_restart_clk", clk_out, 1);
    chk("rr_restart_div", cur_div, 1);
    step();
    chk("rr_restart_low", clk_out, 0);
    step();
    chk("rr_restart_tick2", tick, 1);
    step();
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
